mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a fixed-latency request/response handshake.
// A request taken in IDLE is held for LATENCY BUSY cycles, committed on the
// BUSY->DONE edge, and acknowledged by one DONE cycle with resp high.
module mem_responder #(
  parameter int unsigned LATENCY   = 2,  // BUSY cycles per transaction, 1..15
  parameter int unsigned ADDR_BITS = 8   // log2 of storage depth in words
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        resp,
  output logic        ready,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  state_t                 state_q;
  logic [3:0]             count_q;
  logic                   op_write_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [3:0]             be_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic [31:0]            mem_q [DEPTH];

  logic                   req;
  logic                   finish;
  logic [ADDR_BITS-1:0]   idx_d;

  // Byte-address bits outside the word index are deliberately ignored, so the
  // storage aliases (wraps) across the full 32-bit address space.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:ADDR_BITS+2], address[1:0]};

  assign idx_d  = address[ADDR_BITS+1:2];
  assign req    = (read | write) & ~stall;
  assign finish = (state_q == BUSY) && (count_q == 4'd0);

  // resp drops in the very cycle a request is seen in IDLE, so it cannot be a flop.
  assign resp  = (state_q == DONE) || ((state_q == IDLE) && !req);
  assign ready = (state_q != BUSY);
  assign rdata = rdata_q;

  // Handshake FSM: accept in IDLE, count down in BUSY, acknowledge for one DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples the
      // pre-edge values; blocking here would let later lines see updated state.
      unique case (state_q)
        IDLE: begin
          if (req) begin
            // write wins when both read and write are raised
            op_write_q <= write;
            idx_q      <= idx_d;
            be_q       <= byte_enable;
            wdata_q    <= wdata;
            count_q    <= 4'(LATENCY - 1);
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Storage commit of a latched write on the BUSY->DONE edge, lane by lane.
  // NOTE: the array has no reset branch on purpose; contents survive rst and a
  // reset loop over every word would not map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (finish && op_write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Read-data register: loads only when a read completes, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else if (finish && !op_write_q) begin
      rdata_q <= mem_q[idx_q];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LATENCY=2, ADDR_BITS=8). Inputs are driven
// 1ns after the rising edge and outputs sampled 1ns after that.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [3:0]  byte_enable;
  logic [31:0] wdata;
  logic        stall;
  logic        resp;
  logic        ready;
  logic [31:0] rdata;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  mem_responder #(
    .LATENCY  (2),
    .ADDR_BITS(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read       (read),
    .write      (write),
    .address    (address),
    .byte_enable(byte_enable),
    .wdata      (wdata),
    .stall      (stall),
    .resp       (resp),
    .ready      (ready),
    .rdata      (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read        = 1'b0;
    write       = 1'b0;
    stall       = 1'b0;
    address     = 32'h0;
    byte_enable = 4'h0;
    wdata       = 32'h0;
  endtask

  // One complete transaction starting in an IDLE cycle. Inputs are scrambled
  // during BUSY/DONE so only the latched request can produce the expected result.
  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] exp_rdata);
    read = rd; write = wr; address = addr; byte_enable = be; wdata = wd; stall = 1'b0;
    #1;
    check({tag, " c0 resp"}, 32'(resp), 32'd0);
    check({tag, " c0 ready"}, 32'(ready), 32'd1);
    cyc();
    read = 1'b0; write = 1'b0; address = 32'hFFFF_FFFC; byte_enable = 4'hF; wdata = 32'h5A5A_5A5A;
    #1;
    check({tag, " c1 resp"}, 32'(resp), 32'd0);
    check({tag, " c1 ready"}, 32'(ready), 32'd0);
    cyc();
    read = 1'b1; write = 1'b1;
    #1;
    check({tag, " c2 resp"}, 32'(resp), 32'd0);
    check({tag, " c2 ready"}, 32'(ready), 32'd0);
    cyc();
    check({tag, " c3 resp"}, 32'(resp), 32'd1);
    check({tag, " c3 ready"}, 32'(ready), 32'd1);
    check({tag, " c3 rdata"}, rdata, exp_rdata);
    idle_inputs();
    cyc();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset resp", 32'(resp), 32'd1);
    check("reset ready", 32'(ready), 32'd1);
    check("reset rdata", rdata, 32'h0);
    cyc();
    cyc();
    rst = 1'b0;

    // Full write handshake, then read back in the next IDLE cycle.
    txn("wr10", 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0);
    check("idle after wr resp", 32'(resp), 32'd1);
    txn("rd10", 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold rdata %0d", i), rdata, 32'hDEAD_BEEF);
      check($sformatf("hold resp %0d", i), 32'(resp), 32'd1);
      cyc();
    end

    // Single-lane write into byte 1 of word 4.
    txn("wr11 be2", 1'b0, 1'b1, 32'h11, 4'h2, 32'h0000_AB00, 32'hDEAD_BEEF);
    txn("rd10 merged", 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAD_ABEF);

    // 0x410 wraps onto word 4.
    txn("wr alias", 1'b0, 1'b1, 32'h10 + (32'd4 << 8), 4'hF, 32'h0000_0001, 32'hDEAD_ABEF);
    txn("rd10 alias", 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 32'h0000_0001);

    // Put distinct data in rdata, then a read+write with no lanes enabled.
    txn("wr20", 1'b0, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 32'h0000_0001);
    txn("rd20", 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFE_F00D);
    txn("rw be0", 1'b1, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    txn("rd10 after be0", 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 32'h0000_0001);

    // Stalled read must never be accepted.
    read = 1'b1; stall = 1'b1; address = 32'h20;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall resp %0d", i), 32'(resp), 32'd1);
      check($sformatf("stall ready %0d", i), 32'(ready), 32'd1);
      cyc();
    end
    check("stall rdata", rdata, 32'h0000_0001);
    idle_inputs();
    cyc();

    // Reset in the middle of a write aborts it.
    read = 1'b0; write = 1'b1; address = 32'h20; byte_enable = 4'hF; wdata = 32'h1234_5678;
    cyc();
    idle_inputs();
    #1;
    check("pre-rst busy ready", 32'(ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("async rst resp", 32'(resp), 32'd1);
    check("async rst ready", 32'(ready), 32'd1);
    check("async rst rdata", rdata, 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
    txn("rd20 after rst", 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
